// File: rtl/riscv_core_amo_ctrl.sv
// rtl/riscv_core_amo_ctrl.sv - RISC-V A-extension sequencer (AMO/LR/SC) with embedded AMO ALU
// Runs one atomic at a time against the data-memory port and owns the LR/SC reservation.

module riscv_core_amo_alu #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] mem,
  input  logic [DATA_WIDTH-1:0] core,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = core;
    case (op)
      4'd0: result = core;
      4'd1: result = mem + core;
      4'd2: result = mem & core;
      4'd3: result = mem | core;
      4'd4: result = mem ^ core;
      4'd5: result = ($signed(mem) > $signed(core)) ? mem : core;
      4'd6: result = ($signed(mem) < $signed(core)) ? mem : core;
      4'd7: result = (mem > core) ? mem : core;
      4'd8: result = (mem < core) ? mem : core;
      default: result = core;
    endcase
  end

endmodule

module riscv_core_amo_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_amo_valid,
  output logic                  o_amo_ready,
  input  logic [3:0]            i_amo_op,
  input  logic                  i_amo_word,
  input  logic [ADDR_WIDTH-1:0] i_amo_addr,
  input  logic [DATA_WIDTH-1:0] i_amo_wdata,
  output logic                  o_amo_rvalid,
  output logic [DATA_WIDTH-1:0] o_amo_rdata,
  output logic                  o_amo_err,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic                  o_mem_word,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_inval_valid,
  input  logic [ADDR_WIDTH-1:0] i_inval_addr,
  output logic                  o_busy
);

  localparam logic [3:0] OP_LR = 4'd9;
  localparam logic [3:0] OP_SC = 4'd10;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP
  } state_t;

  state_t                state;
  logic [3:0]            op_q;
  logic                  word_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  res_valid;
  logic [ADDR_WIDTH-1:0] res_addr;

  logic                  accept;
  logic                  bad_req;
  logic                  sc_hit;
  logic                  lr_set;
  logic                  sc_accept;
  logic [DATA_WIDTH-1:0] old_ext;
  logic [DATA_WIDTH-1:0] core_ext;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [DATA_WIDTH-1:0] sc_data;

  assign accept    = i_amo_valid && o_amo_ready;
  assign bad_req   = (i_amo_op > OP_SC) ||
                     (i_amo_word ? (i_amo_addr[1:0] != 2'b00) : (i_amo_addr[2:0] != 3'b000));
  assign sc_hit    = res_valid && ((i_amo_addr >> 3) == (res_addr >> 3));
  assign sc_accept = accept && !bad_req && (i_amo_op == OP_SC);
  assign lr_set    = (state == RD_WAIT) && i_mem_rvalid && (op_q == OP_LR);

  // Word operands are sign-extended so the unsigned compares order them like 64-bit values.
  assign old_ext  = word_q ? {{(DATA_WIDTH-32){i_mem_rdata[31]}}, i_mem_rdata[31:0]} : i_mem_rdata;
  assign core_ext = word_q ? {{(DATA_WIDTH-32){wdata_q[31]}}, wdata_q[31:0]} : wdata_q;
  assign wb_data  = word_q ? {{(DATA_WIDTH-32){1'b0}}, alu_res[31:0]} : alu_res;
  assign sc_data  = i_amo_word ? {{(DATA_WIDTH-32){1'b0}}, i_amo_wdata[31:0]} : i_amo_wdata;

  riscv_core_amo_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op_q),
    .mem    (old_ext),
    .core   (core_ext),
    .result (alu_res)
  );

  assign o_mem_word = word_q;
  assign o_mem_addr = addr_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      op_q         <= '0;
      word_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      o_amo_ready  <= 1'b1;
      o_amo_rvalid <= 1'b0;
      o_amo_rdata  <= '0;
      o_amo_err    <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_wdata  <= '0;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q        <= i_amo_op;
            word_q      <= i_amo_word;
            addr_q      <= i_amo_addr;
            wdata_q     <= i_amo_wdata;
            o_amo_ready <= 1'b0;
            o_busy      <= 1'b1;
            o_amo_err   <= bad_req;
            if (bad_req) begin
              state        <= RESP;
              o_amo_rvalid <= 1'b1;
              o_amo_rdata  <= '0;
            end else if (i_amo_op == OP_SC) begin
              if (sc_hit) begin
                state       <= WR_REQ;
                o_mem_req   <= 1'b1;
                o_mem_we    <= 1'b1;
                o_mem_wdata <= sc_data;
              end else begin
                state        <= RESP;
                o_amo_rvalid <= 1'b1;
                o_amo_rdata  <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
              end
            end else begin
              state     <= RD_REQ;
              o_mem_req <= 1'b1;
              o_mem_we  <= 1'b0;
            end
          end
        end
        RD_REQ: begin
          if (i_mem_gnt) begin
            state     <= RD_WAIT;
            o_mem_req <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (i_mem_rvalid) begin
            o_amo_rdata <= old_ext;
            if (op_q == OP_LR) begin
              state        <= RESP;
              o_amo_rvalid <= 1'b1;
            end else begin
              state       <= WR_REQ;
              o_mem_req   <= 1'b1;
              o_mem_we    <= 1'b1;
              o_mem_wdata <= wb_data;
            end
          end
        end
        WR_REQ: begin
          if (i_mem_gnt) begin
            state     <= WR_WAIT;
            o_mem_req <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (i_mem_rvalid) begin
            state        <= RESP;
            o_mem_we     <= 1'b0;
            o_amo_rvalid <= 1'b1;
            if (op_q == OP_SC) o_amo_rdata <= '0;
          end
        end
        RESP: begin
          state        <= IDLE;
          o_amo_rvalid <= 1'b0;
          o_amo_ready  <= 1'b1;
          o_busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An invalidate landing on the LR-set cycle is checked against the new address and wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      res_valid <= 1'b0;
      res_addr  <= '0;
    end else if (lr_set) begin
      res_addr  <= addr_q;
      res_valid <= !(i_inval_valid && ((i_inval_addr >> 3) == (addr_q >> 3)));
    end else if (sc_accept) begin
      res_valid <= 1'b0;
    end else if (i_inval_valid && ((i_inval_addr >> 3) == (res_addr >> 3))) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: doc/riscv_core_amo_ctrl.md
Name: riscv_core_amo_ctrl

Overview:
Sequences one RISC-V A-extension operation at a time: AMO read-modify-write, LR or SC. Sits between the core LSU and the data-memory port. Runs the memory read, drives the embedded AMO ALU (riscv_core_amo_alu, op codes 0000-1000), writes the result back and returns the original memory value to the core. Owns the single LR/SC reservation register.

Parameters:
DATA_WIDTH, 64, data path width; operands, memory data and response data.
ADDR_WIDTH, 64, byte address width.

Ports:
i_clk  in  1  clock; all state changes on rising edge.
i_rst_n  in  1  reset; synchronous, active-low.
i_amo_valid  in  1  core request valid.
o_amo_ready  out  1  request accepted this cycle when high with i_amo_valid; high only in IDLE.
i_amo_op  in  4  operation: 0000-1000 = ALU ops (SWAP, ADD, AND, OR, XOR, MAX, MIN, MAXU, MINU), 1001 = LR, 1010 = SC; others reserved.
i_amo_word  in  1  1 = .W (32-bit), 0 = .D (64-bit).
i_amo_addr  in  ADDR_WIDTH  byte address.
i_amo_wdata  in  DATA_WIDTH  core operand / SC store data.
o_amo_rvalid  out  1  one-cycle response strobe.
o_amo_rdata  out  DATA_WIDTH  response: old memory value (AMO/LR), 0/1 (SC), 0 (error).
o_amo_err  out  1  misaligned-address error, valid with o_amo_rvalid.
o_mem_req  out  1  memory request.
o_mem_we  out  1  1 = write.
o_mem_word  out  1  access size, copy of latched i_amo_word.
o_mem_addr  out  ADDR_WIDTH  latched address.
o_mem_wdata  out  DATA_WIDTH  write data.
i_mem_gnt  in  1  request accepted.
i_mem_rvalid  in  1  read data valid / write ack, no earlier than the cycle after gnt.
i_mem_rdata  in  DATA_WIDTH  read data; word right-justified in bits [31:0].
i_inval_valid  in  1  external store/snoop to i_inval_addr.
i_inval_addr  in  ADDR_WIDTH  invalidation address.
o_busy  out  1  state != IDLE.

Behaviour:
- Reset: synchronous. State goes to IDLE on the next edge, including mid-operation. Reservation is cleared. All outputs are 0 except o_amo_ready = 1.
- Accept: in IDLE, valid && ready latches op, word, addr and wdata. Inputs are ignored in all other states.
- State machine: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
  - IDLE, on accept:
    - misaligned (word: addr[1:0] != 0; dword: addr[2:0] != 0): go to RESP with err = 1 and rdata = 0. No memory access, reservation unchanged.
    - SC with reservation valid and addr match: go to WR_REQ.
    - SC otherwise: go to RESP with rdata = 1, no memory access.
    - all other ops: go to RD_REQ.
  - RD_REQ: req = 1, we = 0. Stay until gnt, then RD_WAIT.
  - RD_WAIT: on rvalid, capture old value.
    - Word: old = sign-extended rdata[31:0].
    - LR: set reservation (valid, addr), then RESP.
    - AMO: register ALU result, then WR_REQ.
  - WR_REQ: req = 1, we = 1. wdata = registered ALU result (AMO) or latched wdata (SC). Stay until gnt, then WR_WAIT.
  - WR_WAIT: on rvalid (ack), go to RESP.
  - RESP: o_amo_rvalid = 1 for exactly one cycle, then IDLE.
- ALU operands:
  - mem = old value.
  - core = latched wdata; for word ops, sign-extended wdata[31:0].
  - Sign extension keeps MAXU/MINU ordering correct.
  - Writeback for word ops uses bits [31:0] only.
- Reserved op: treated as error, same path as misaligned.
- Request stability: addr, we, wdata and word hold constant while req is high and gnt is low.
- SC success: rdata = 0 after the write ack.
- Reservation: any SC clears it at accept, whether it succeeds or fails.
- Reservation match: compares addr bits [ADDR_WIDTH-1:3]; granule = 8 bytes.
- Invalidation: i_inval_valid with a matching granule clears the reservation.
  - If it coincides with the LR-set cycle, the invalidate wins and the reservation stays clear.
  - Invalidation never aborts an in-flight operation.
- Minimum latency (gnt same cycle as req, rvalid next cycle):
  - AMO: accept T0, rvalid T5.
  - LR: T3.
  - Failed SC or error: T1.

Test Plan:
- AMOADD.D: mem[0x100] = 5, wdata = 3, gnt/rvalid immediate -> one read then one write of 8 to 0x100; rdata = 5 at T5; o_busy high T1-T5.
- AMOMAXU.W: mem word 0xFFFFFFFF, wdata 0x00000001 -> write 0xFFFFFFFF, rdata = 0xFFFFFFFFFFFFFFFF. AMOMIN.W on the same values -> write 0xFFFFFFFF.
- LR.D 0x200 then SC.D 0x200 wdata 0xAB -> SC writes 0xAB, rdata 0. A second SC.D -> rdata 1, no o_mem_req.
- LR 0x200, then i_inval_valid with addr 0x204 -> following SC fails (rdata 1). Invalidate on the LR-rvalid cycle -> SC also fails.
- AMOSWAP.W at addr 0x102 -> o_amo_err = 1, rdata 0 at T1, no memory request. Reserved op 1111 -> same response.
- gnt withheld 4 cycles in RD_REQ, then i_rst_n low one cycle -> req/addr stable while waiting; after reset, IDLE, o_mem_req = 0, o_amo_ready = 1, reservation cleared.
